pipelined_unsigned_booth_multiplier: RTL and testbench

- Parametrised, pipelined unsigned N×N multiplier for the posit FMA mantissa datapath.
- Generalises the fixed 7×7 combinational radix-4 Booth multiplier to any WIDTH and carries a caller TAG alongside each operation.
- Has a 3-stage registered pipeline with valid/ready handshake and backpressure.
- Sits between posit decode (fraction extraction) and the normalise/round stage.

---
 rtl/pipelined_unsigned_booth_multiplier_pkg.sv | 65 ++++++
 rtl/pipelined_unsigned_booth_multiplier_pp_row.sv | 41 ++++
 rtl/pipelined_unsigned_booth_multiplier.sv | 208 ++++++++++++++++++++
 tb/tb_pipelined_unsigned_booth_multiplier.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_unsigned_booth_multiplier_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared types and elaboration-time helpers for the radix-4
//               Booth multiplier: Booth selection encoding, partial-product
//               count and carry-save tree shape.
// Revision    : 1.0 - initial release
// Ports       : none (package)
// ============================================================================
package mult_pkg;

    // Radix-4 Booth digit selected by one 3-bit multiplier window.
    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } booth_sel_e;

    // Unsigned operands are zero-extended by two bits, which adds one group.
    function automatic int num_pp(input int width);
        return width / 2 + 1;
    endfunction

    // Window {b[2i+1], b[2i], b[2i-1]} -> digit in {-2,-1,0,+1,+2}.
    function automatic booth_sel_e booth_encode(input logic [2:0] trip);
        booth_sel_e sel;
        case (trip)
            3'b001, 3'b010: sel = POS1;
            3'b011:         sel = POS2;
            3'b100:         sel = NEG2;
            3'b101, 3'b110: sel = NEG1;
            default:        sel = ZERO;
        endcase
        return sel;
    endfunction

    // Rows still present after lvl levels of 3:2 compression of n rows.
    function automatic int csa_rows(input int n, input int lvl);
        int rows;
        rows = n;
        for (int l = 0; l < lvl; l++) begin
            if (rows > 2) begin
                rows = 2 * (rows / 3) + rows % 3;
            end
        end
        return rows;
    endfunction

    // Number of 3:2 levels needed to bring n rows down to two.
    function automatic int csa_levels(input int n);
        int rows;
        int lv;
        rows = n;
        lv   = 0;
        while (rows > 2) begin
            rows = 2 * (rows / 3) + rows % 3;
            lv++;
        end
        return lv;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_unsigned_booth_multiplier_pp_row.sv
`default_nettype none
// ============================================================================
// Module      : booth_r4_pp_row
// Description : One radix-4 Booth partial-product row (unshifted). Selects
//               0 / +A / +2A / -A / -2A from a 3-bit multiplier window and
//               returns it as a 2*WIDTH-bit two's-complement row.
// Revision    : 1.0 - initial release
// Ports       : triplet_i  [2:0]         Booth window of the multiplier
//               a_i        [WIDTH-1:0]   unsigned multiplicand
//               row_o      [2*WIDTH-1:0] selected multiple, full width
// ============================================================================
module booth_r4_pp_row
    import mult_pkg::*;
#(
    parameter int WIDTH = 7
) (
    input  logic [2:0]         triplet_i,
    input  logic [WIDTH-1:0]   a_i,
    output logic [2*WIDTH-1:0] row_o
);

    booth_sel_e           sel;
    logic [2*WIDTH-1:0]   a_ext;

    // Negative multiples are produced as full-width two's complement, so the
    // sign extension is already folded into the row and summing all rows
    // modulo 2^(2*WIDTH) gives the exact unsigned product.
    always_comb begin
        sel   = booth_encode(triplet_i);
        a_ext = {{WIDTH{1'b0}}, a_i};
        case (sel)
            POS1:    row_o = a_ext;
            POS2:    row_o = a_ext << 1;
            NEG1:    row_o = -a_ext;
            NEG2:    row_o = -(a_ext << 1);
            default: row_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pipelined_unsigned_booth_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_unsigned_booth_multiplier
// Description : 3-stage pipelined unsigned WIDTH x WIDTH radix-4 Booth
//               multiplier with valid/ready handshake and a sideband tag.
//               S1 Booth partial products, S2 carry-save tree, S3 prefix add.
// Revision    : 1.0 - initial release
// Ports       : clk          clock, rising edge
//               rst          synchronous active-high reset
//               in_valid     operands valid
//               in_ready     operands accepted this cycle
//               in_a, in_b   unsigned operands [WIDTH-1:0]
//               in_tag       sideband tag [TAG_W-1:0]
//               out_valid    product valid
//               out_ready    consumer accepts product
//               out_product  exact product [2*WIDTH-1:0]
//               out_tag      tag travelling with the product
// ============================================================================
module pipelined_unsigned_booth_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 7,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int NPP  = num_pp(WIDTH);
    localparam int PW   = 2 * WIDTH;
    localparam int BX   = 2 * NPP + 1;       // extended multiplier width
    localparam int NLVL = csa_levels(NPP);
    localparam int M    = PW - 1;            // carry positions that matter
    localparam int KL   = $clog2(M);         // prefix-tree depth

    // ------------------------------------------------------------------
    // Handshake: each stage may load when empty or when the stage after it
    // loads, so bubbles collapse and a full pipe still moves when drained.
    // ------------------------------------------------------------------
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic out_valid_q, out_valid_d;
    logic s1_en, s2_en, s3_en;
    logic s1_load, s2_load, s3_load;

    assign s3_en    = !out_valid_q || out_ready;
    assign s2_en    = !s2_valid_q || s3_en;
    assign s1_en    = !s1_valid_q || s2_en;
    assign in_ready = s1_en && !rst;

    assign s1_load  = in_valid && in_ready;
    assign s2_load  = s2_en && s1_valid_q;
    assign s3_load  = s3_en && s2_valid_q;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s2_valid_d  = s2_valid_q;
        out_valid_d = out_valid_q;
        if (s1_en) s1_valid_d  = in_valid;
        if (s2_en) s2_valid_d  = s1_valid_q;
        if (s3_en) out_valid_d = s2_valid_q;
    end

    // ------------------------------------------------------------------
    // S1: Booth partial products. The multiplier is zero-extended with an
    // implicit 0 below bit 0; window i covers bits [2i+1 : 2i-1].
    // ------------------------------------------------------------------
    logic [BX-1:0]    b_ext;
    logic [PW-1:0]    pp_row [NPP];
    logic [PW-1:0]    pp_q   [NPP];
    logic [TAG_W-1:0] s1_tag_q;

    assign b_ext = {{(BX - WIDTH - 1){1'b0}}, in_b, 1'b0};

    for (genvar i = 0; i < NPP; i++) begin : g_pp
        logic [PW-1:0] row_raw;
        booth_r4_pp_row #(
            .WIDTH (WIDTH)
        ) u_row (
            .triplet_i (b_ext[2*i+2:2*i]),
            .a_i       (in_a),
            .row_o     (row_raw)
        );
        assign pp_row[i] = row_raw << (2 * i);
    end

    always_ff @(posedge clk) begin
        if (s1_load) begin
            for (int i = 0; i < NPP; i++) begin
                pp_q[i] <= pp_row[i];
            end
            s1_tag_q <= in_tag;
        end
    end

    // ------------------------------------------------------------------
    // S2: Wallace reduction. Each level compresses groups of three rows
    // into sum/carry, passes leftovers through and zeroes unused slots.
    // ------------------------------------------------------------------
    logic [PW-1:0]    csa [NLVL+1][NPP];
    logic [PW-1:0]    sum_q, carry_q;
    logic [TAG_W-1:0] s2_tag_q;

    for (genvar i = 0; i < NPP; i++) begin : g_csa_in
        assign csa[0][i] = pp_q[i];
    end

    for (genvar l = 0; l < NLVL; l++) begin : g_csa_lvl
        localparam int N_IN  = csa_rows(NPP, l);
        localparam int N_GRP = N_IN / 3;
        localparam int N_REM = N_IN % 3;

        for (genvar g = 0; g < N_GRP; g++) begin : g_fa
            logic [PW-1:0] x, y, z;
            assign x = csa[l][3*g];
            assign y = csa[l][3*g+1];
            assign z = csa[l][3*g+2];
            assign csa[l+1][2*g]   = x ^ y ^ z;
            // Carries out of the top column fall outside the product.
            assign csa[l+1][2*g+1] = {(x[PW-2:0] & y[PW-2:0]) |
                                      (x[PW-2:0] & z[PW-2:0]) |
                                      (y[PW-2:0] & z[PW-2:0]), 1'b0};
        end

        for (genvar r = 0; r < N_REM; r++) begin : g_pass
            assign csa[l+1][2*N_GRP+r] = csa[l][3*N_GRP+r];
        end

        for (genvar u = 2 * N_GRP + N_REM; u < NPP; u++) begin : g_unused
            assign csa[l+1][u] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (s2_load) begin
            sum_q    <= csa[NLVL][0];
            carry_q  <= csa[NLVL][1];
            s2_tag_q <= s1_tag_q;
        end
    end

    // ------------------------------------------------------------------
    // S3: Kogge-Stone carry-propagate add. Only carries into bits
    // 1..PW-1 are needed; the carry-out is always zero for these rows.
    // ------------------------------------------------------------------
    logic [PW-1:0] ks_x;
    logic [M-1:0]  ks_g [KL+1];
    logic [M-1:0]  ks_p [KL+1];
    logic [PW-1:0] sum_final;

    assign ks_x    = sum_q ^ carry_q;
    assign ks_g[0] = sum_q[M-1:0] & carry_q[M-1:0];
    assign ks_p[0] = ks_x[M-1:0];

    for (genvar k = 0; k < KL; k++) begin : g_ks_lvl
        for (genvar i = 0; i < M; i++) begin : g_ks_bit
            if (i >= (1 << k)) begin : g_merge
                assign ks_g[k+1][i] = ks_g[k][i] |
                                      (ks_p[k][i] & ks_g[k][i-(1<<k)]);
                assign ks_p[k+1][i] = ks_p[k][i] & ks_p[k][i-(1<<k)];
            end else begin : g_keep
                assign ks_g[k+1][i] = ks_g[k][i];
                assign ks_p[k+1][i] = ks_p[k][i];
            end
        end
    end

    assign sum_final = ks_x ^ {ks_g[KL], 1'b0};

    // ------------------------------------------------------------------
    // Valid flags and output registers are the only reset state.
    // ------------------------------------------------------------------
    logic [PW-1:0]    out_product_q;
    logic [TAG_W-1:0] out_tag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s2_valid_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_product_q <= '0;
            out_tag_q     <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            out_valid_q <= out_valid_d;
            if (s3_load) begin
                out_product_q <= sum_final;
                out_tag_q     <= s2_tag_q;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_product = out_product_q;
    assign out_tag     = out_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_unsigned_booth_multiplier.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_pipelined_unsigned_booth_multiplier
// Description : Self-checking bench for the pipelined Booth multiplier.
//               Five instances (WIDTH 5, 7, 8, 16, 32) share clk/rst; one
//               instance is exercised at a time against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_unsigned_booth_multiplier;

    localparam int NDUT = 5;
    localparam int WID [NDUT] = '{5, 7, 8, 16, 32};
    localparam int TW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          rst;
    logic          iv     [NDUT];
    logic [31:0]   ia     [NDUT];
    logic [31:0]   ib     [NDUT];
    logic [TW-1:0] itag   [NDUT];
    logic          ordy   [NDUT];
    logic          ir_w   [NDUT];
    logic          ov_w   [NDUT];
    logic [63:0]   prod_w [NDUT];
    logic [TW-1:0] otag_w [NDUT];

    for (genvar k = 0; k < NDUT; k++) begin : g_dut
        localparam int W = WID[k];
        logic [2*W-1:0] prod;
        logic [TW-1:0]  otag;
        logic           ir, ov;
        pipelined_unsigned_booth_multiplier #(
            .WIDTH (W),
            .TAG_W (TW)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .in_valid    (iv[k]),
            .in_ready    (ir),
            .in_a        (ia[k][W-1:0]),
            .in_b        (ib[k][W-1:0]),
            .in_tag      (itag[k]),
            .out_valid   (ov),
            .out_ready   (ordy[k]),
            .out_product (prod),
            .out_tag     (otag)
        );
        assign ir_w[k]   = ir;
        assign ov_w[k]   = ov;
        assign prod_w[k] = 64'(prod);
        assign otag_w[k] = otag;
    end

    typedef struct {
        logic [63:0]   prod;
        logic [TW-1:0] tag;
        int            acc_cyc;
    } exp_t;

    exp_t exp_q [$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    logic          last_acc;
    logic          last_drain;
    logic [63:0]   last_prod;
    logic [TW-1:0] last_tag;
    int            last_lat;

    // One clock cycle on instance k: drive after the falling edge, observe
    // 1 ns later, and update the in-order reference queue.
    task automatic step(input int k, input logic rs, input logic v,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [TW-1:0] t, input logic r);
        exp_t e;
        @(negedge clk);
        rst = rs; iv[k] = v; ia[k] = a; ib[k] = b; itag[k] = t; ordy[k] = r;
        #1;
        last_acc   = 1'b0;
        last_drain = 1'b0;
        if (rs) begin
            check("in_ready_in_reset", 64'(ir_w[k]), 64'd0);
            exp_q.delete();
        end else begin
            check("in_ready_rule", 64'(ir_w[k]), 64'(exp_q.size() < 3 || r));
            if (ov_w[k] && r) begin
                last_drain = 1'b1;
                last_prod  = prod_w[k];
                last_tag   = otag_w[k];
                check("drain_has_pending_op", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    last_lat = cyc - e.acc_cyc;
                    check("product", prod_w[k], e.prod);
                    check("tag", 64'(otag_w[k]), 64'(e.tag));
                end
            end
            if (v && ir_w[k]) begin
                last_acc  = 1'b1;
                e.prod    = 64'(a) * 64'(b);
                e.tag     = t;
                e.acc_cyc = cyc;
                exp_q.push_back(e);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0]   ta [5];
        logic [31:0]   tb [5];
        logic [63:0]   gotp [4];
        int            dc [4];
        logic [TW-1:0] dtag [4];
        int            nacc, ndr, nhold, nboth, nspur, ncyc, k;
        logic          got;
        logic [31:0]   mask, a, b;

        rst = 1'b1;
        for (int i = 0; i < NDUT; i++) begin
            iv[i] = 1'b0; ia[i] = '0; ib[i] = '0; itag[i] = '0; ordy[i] = 1'b1;
        end

        // ---------------- reset state ----------------
        for (int n = 0; n < 3; n++) step(1, 1'b1, 1'b0, 0, 0, 0, 1'b1);
        for (int i = 0; i < NDUT; i++) begin
            check("rst_out_valid", 64'(ov_w[i]), 64'd0);
            check("rst_out_product", prod_w[i], 64'd0);
            check("rst_out_tag", 64'(otag_w[i]), 64'd0);
        end
        step(1, 1'b0, 1'b0, 0, 0, 0, 1'b1);
        check("in_ready_after_rst", 64'(ir_w[1]), 64'd1);

        // ---------------- single op, WIDTH=7 ----------------
        step(1, 1'b0, 1'b1, 127, 127, 5, 1'b1);
        check("t1_accept", 64'(last_acc), 64'd1);
        got = 1'b0;
        for (int n = 0; n < 10; n++) begin
            step(1, 1'b0, 1'b0, 0, 0, 0, 1'b1);
            if (last_drain) begin got = 1'b1; break; end
        end
        check("t1_drained", 64'(got), 64'd1);
        check("t1_latency", 64'(last_lat), 64'd3);
        check("t1_product", last_prod, 64'd16129);
        check("t1_tag", 64'(last_tag), 64'd5);

        // ---------------- back-to-back stream, WIDTH=8 ----------------
        ta = '{255, 0, 1, 170, 0};
        tb = '{255, 200, 1, 85, 0};
        ndr = 0;
        for (int n = 0; n < 16 && ndr < 4; n++) begin
            step(2, 1'b0, n < 4, (n < 4) ? ta[n] : 0, (n < 4) ? tb[n] : 0, TW'(n), 1'b1);
            if (n < 4) check("t2_accept", 64'(last_acc), 64'd1);
            if (last_drain) begin
                gotp[ndr] = last_prod; dc[ndr] = cyc; ndr++;
            end
        end
        check("t2_count", 64'(ndr), 64'd4);
        check("t2_p0", gotp[0], 64'd65025);
        check("t2_p1", gotp[1], 64'd0);
        check("t2_p2", gotp[2], 64'd1);
        check("t2_p3", gotp[3], 64'd14450);
        check("t2_consecutive", 64'(dc[3] - dc[0]), 64'd3);

        // ---------------- backpressure, WIDTH=7 ----------------
        ta = '{100, 3, 127, 64, 0};
        tb = '{50, 0, 127, 2, 0};
        nacc = 0; nhold = 0;
        for (int n = 0; n < 6; n++) begin
            step(1, 1'b0, 1'b1, ta[nacc], tb[nacc], TW'(nacc + 1), 1'b0);
            if (last_acc) nacc++;
            if (ov_w[1]) begin
                nhold++;
                check("t3_hold_product", prod_w[1], 64'd5000);
                check("t3_hold_tag", 64'(otag_w[1]), 64'd1);
            end
        end
        check("t3_accepts", 64'(nacc), 64'd3);
        check("t3_in_ready_low", 64'(ir_w[1]), 64'd0);
        check("t3_hold_cycles", 64'(nhold), 64'd3);
        ndr = 0;
        for (int n = 0; n < 20 && ndr < 4; n++) begin
            step(1, 1'b0, nacc < 4, (nacc < 4) ? ta[nacc] : 0, (nacc < 4) ? tb[nacc] : 0,
                 TW'(nacc + 1), 1'b1);
            if (last_acc) nacc++;
            if (last_drain) begin dtag[ndr] = last_tag; ndr++; end
        end
        check("t3_drained", 64'(ndr), 64'd4);
        check("t3_order0", 64'(dtag[0]), 64'd1);
        check("t3_order3", 64'(dtag[3]), 64'd4);
        check("t3_empty", 64'(exp_q.size()), 64'd0);

        // ---------------- accept/drain on a full pipe ----------------
        nacc = 0; ndr = 0; nboth = 0;
        for (int n = 0; n < 30; n++) begin
            step(1, 1'b0, 1'b1, 32'(nacc + 3), 32'(nacc + 1), TW'(nacc), (n >= 3) && (n % 2 == 1));
            if (last_acc) nacc++;
            if (last_drain) ndr++;
            if (last_acc && last_drain) nboth++;
            check("t4_occupancy", 64'(exp_q.size() <= 3), 64'd1);
        end
        for (int n = 0; n < 12 && exp_q.size() != 0; n++) begin
            step(1, 1'b0, 1'b0, 0, 0, 0, 1'b1);
            if (last_drain) ndr++;
        end
        check("t4_all_drained", 64'(ndr), 64'(nacc));
        check("t4_simultaneous_seen", 64'(nboth > 0), 64'd1);

        // ---------------- reset mid-operation ----------------
        step(1, 1'b0, 1'b1, 11, 12, 9, 1'b1);
        step(1, 1'b0, 1'b1, 13, 14, 10, 1'b1);
        step(1, 1'b1, 1'b0, 0, 0, 0, 1'b1);
        step(1, 1'b0, 1'b0, 0, 0, 0, 1'b1);
        check("t5_out_valid", 64'(ov_w[1]), 64'd0);
        check("t5_out_product", prod_w[1], 64'd0);
        check("t5_in_ready", 64'(ir_w[1]), 64'd1);
        nspur = 0;
        for (int n = 0; n < 8; n++) begin
            step(1, 1'b0, 1'b0, 0, 0, 0, 1'b1);
            if (ov_w[1]) nspur++;
        end
        check("t5_no_stale_output", 64'(nspur), 64'd0);

        // ---------------- randomised, WIDTH 5/7/16/32 ----------------
        for (int w = 0; w < 4; w++) begin
            k = (w == 0) ? 0 : (w == 1) ? 1 : (w == 2) ? 3 : 4;
            mask = 32'((64'd1 << WID[k]) - 64'd1);
            nacc = 0; ncyc = 0;
            while (nacc < 2500 && ncyc < 20000) begin
                case ($urandom_range(0, 7))
                    0:       a = 0;
                    1:       a = mask;
                    default: a = $urandom & mask;
                endcase
                case ($urandom_range(0, 7))
                    0:       b = 0;
                    1:       b = mask;
                    default: b = $urandom & mask;
                endcase
                step(k, 1'b0, $urandom_range(0, 3) != 0, a, b, TW'($urandom_range(0, 15)),
                     $urandom_range(0, 3) != 0);
                if (last_acc) nacc++;
                ncyc++;
            end
            check("t6_ops_accepted", 64'(nacc), 64'd2500);
            for (int n = 0; n < 20 && exp_q.size() != 0; n++) begin
                step(k, 1'b0, 1'b0, 0, 0, 0, 1'b1);
            end
            check("t6_drained", 64'(exp_q.size()), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
